em_master: RTL

EM_MASTER -- requirements
Module: em_master

---
 rtl/em_pkg.sv | 20 ++
 rtl/em_shift_tx.sv | 46 ++++
 rtl/em_master.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/em_pkg.sv
// Shared definitions for the em serial-bus master and slave-side benches:
// the 4-bit state encoding and the default word, address and timeout sizes.
package em_pkg;

  localparam int EM_N         = 8;   // data word width
  localparam int EM_ADN       = 12;  // address length, sent MSB first
  localparam int EM_TIMEOUT_N = 64;  // read-response timeout in cycles

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_REQ   = 4'd1,
    ST_START = 4'd2,
    ST_ADDR  = 4'd3,
    ST_WDONE = 4'd4,
    ST_RWAIT = 4'd5,
    ST_RDATA = 4'd6,
    ST_RSP   = 4'd7
  } em_state_e;

endpackage

// File: rtl/em_shift_tx.sv
// Parallel-load, MSB-first serialiser. The serial bit is a register that
// reads 0 after load or clear; done rises with the W-th shifted bit and
// stays high until the next load.
module em_shift_tx #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         shift,
  input  logic         clear,
  output logic         bit_out,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;

  // Load the word, then present one bit per shift, MSB first.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here is assigned with <=, so all of them update
    // together from the values held before the edge.
    if (!reset) begin
      sreg    <= '0;
      cnt     <= '0;
      bit_out <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      sreg    <= data;
      cnt     <= '0;
      bit_out <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      bit_out <= 1'b0;
    end else if (shift) begin
      bit_out <= sreg[W-1];
      sreg    <= sreg << 1;
      cnt     <= cnt + 1'b1;
      done    <= (cnt == CW'(W - 1));
    end
  end

endmodule

// File: rtl/em_master.sv
// Serial-bus master: accepts a user read/write command, arbitrates for the
// bus, serialises start + address (+ write data) to the slave, and
// deserialises the read response.
// Optional feature: define EM_MASTER_TIMEOUT_EN to enable the read timeout
// (RdErr pulse); otherwise RdErr is tied 0 and reads wait indefinitely.
module em_master
  import em_pkg::*;
#(
  parameter int N        = EM_N,
  parameter int ADN      = EM_ADN,
  parameter int TimeoutN = EM_TIMEOUT_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           CmdValid,
  output logic           CmdReady,
  input  logic           CmdWren,
  input  logic [ADN-1:0] CmdAddr,
  input  logic [N-1:0]   CmdData,
  output logic           RdValid,
  output logic [N-1:0]   RdData,
  output logic           RdErr,
  output logic           Busy,
  output logic           BusReq,
  input  logic           BusGrant,
  output logic           SValid,
  output logic           SWren,
  output logic           SAddr,
  output logic           SData,
  input  logic           SReady,
  input  logic           SValidIn,
  input  logic           SDataIn,
  input  logic           SHold
);

  localparam int CNW = $clog2(N) + 1;

  em_state_e      state;
  logic           wren_q;
  logic [CNW-1:0] cnt;
  logic [N-1:0]   rx;
  logic [N-1:0]   rx_next;
  logic           rd_last;
  logic           tx_load, tx_shift, tx_clear;
  logic           addr_done, data_done;

  // Serialiser control; data is zero-extended so it lands in the last N bits.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch,
    // so no path leaves it holding state and no latch is inferred.
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_clear = 1'b0;
    rx_next  = {rx[N-2:0], SDataIn};
    rd_last  = (state == ST_RDATA) && SValidIn && (cnt == CNW'(N - 1));
    if (state == ST_IDLE && CmdValid && CmdReady) tx_load = 1'b1;
    if (state == ST_START) tx_shift = 1'b1;
    if (state == ST_ADDR) begin
      tx_shift = !addr_done;
      tx_clear = addr_done;
    end
  end

  em_shift_tx #(.W(ADN)) u_addr_tx (
    .clk(clk), .reset(reset), .load(tx_load), .data(CmdAddr),
    .shift(tx_shift), .clear(tx_clear), .bit_out(SAddr), .done(addr_done)
  );

  em_shift_tx #(.W(ADN)) u_data_tx (
    .clk(clk), .reset(reset), .load(tx_load),
    .data(CmdWren ? ADN'(CmdData) : '0),
    .shift(tx_shift), .clear(tx_clear), .bit_out(SData), .done(data_done)
  );

`ifdef EM_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutN + 1);
  logic [TW-1:0] tcnt;
`else
  assign RdErr = 1'b0;
`endif

  // Transaction FSM with registered handshake, bus and serial-control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wren_q   <= 1'b0;
      cnt      <= '0;
      rx       <= '0;
      CmdReady <= 1'b0;
      RdValid  <= 1'b0;
      RdData   <= '0;
      Busy     <= 1'b0;
      BusReq   <= 1'b0;
      SValid   <= 1'b0;
      SWren    <= 1'b0;
`ifdef EM_MASTER_TIMEOUT_EN
      RdErr    <= 1'b0;
      tcnt     <= '0;
`endif
    end else begin
      RdValid <= 1'b0;
`ifdef EM_MASTER_TIMEOUT_EN
      RdErr   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (CmdValid && CmdReady) begin
            wren_q   <= CmdWren;
            CmdReady <= 1'b0;
            Busy     <= 1'b1;
            BusReq   <= 1'b1;
            state    <= ST_REQ;
          end else begin
            CmdReady <= 1'b1;
          end
        end
        ST_REQ: begin
          if (BusGrant && SReady) begin
            SValid <= 1'b1;
            SWren  <= wren_q;
            state  <= ST_START;
          end
        end
        ST_START: state <= ST_ADDR;
        ST_ADDR: begin
          if (addr_done) begin
            SValid <= 1'b0;
            SWren  <= 1'b0;
            cnt    <= '0;
            state  <= wren_q ? ST_WDONE : ST_RWAIT;
          end
        end
        ST_WDONE: begin
          if (cnt == CNW'(1)) begin
            BusReq   <= 1'b0;
            Busy     <= 1'b0;
            CmdReady <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RWAIT: begin
          // The first valid cycle is the slave's load cycle; its bit is dropped.
          if (SValidIn) begin
            cnt   <= '0;
            state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (SValidIn) begin
            rx  <= rx_next;
            cnt <= cnt + 1'b1;
            if (rd_last) begin
              RdData  <= rx_next;
              RdValid <= 1'b1;
              state   <= ST_RSP;
            end
          end
        end
        ST_RSP: begin
          BusReq   <= 1'b0;
          Busy     <= 1'b0;
          CmdReady <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef EM_MASTER_TIMEOUT_EN
      // A completing last bit wins over a timeout in the same cycle.
      if (state == ST_RWAIT || state == ST_RDATA) begin
        if (tcnt == TW'(TimeoutN - 1) && !rd_last) begin
          RdErr    <= 1'b1;
          BusReq   <= 1'b0;
          Busy     <= 1'b0;
          CmdReady <= 1'b1;
          state    <= ST_IDLE;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
`endif
    end
  end

  // SHold is status only; the data serialiser's done mirrors the address one.
  logic unused_ok;
  assign unused_ok = &{1'b0, SHold, data_done, 32'(TimeoutN)};

endmodule
